click_sequence_decoder: RTL and testbench

- Sits directly downstream of the button debouncer. Consumes its single-cycle press pulse and groups presses that fall within a time window into one multi-click event (single, double or triple click).
- Presents each event to the control logic through a registered valid/ready output with overflow detection.
- Clocked at 5 MHz, same clock domain as the debouncer.

---
 rtl/click_sequence_decoder.sv | 125 ++++++++++++
 tb/tb_click_sequence_decoder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/click_sequence_decoder.sv
// Groups debounced press pulses that fall within a merge window into one
// multi-click event, presented through a registered valid/ready output.
module click_sequence_decoder #(
    parameter int unsigned WINDOW     = 2000000,
    parameter int unsigned TIMER_W    = 21,
    parameter int unsigned CLICK_W    = 2,
    parameter int unsigned MAX_CLICKS = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               press,
    input  logic               ev_ready,
    output logic               ev_valid,
    output logic [CLICK_W-1:0] ev_count,
    output logic               busy,
    output logic               overflow
);

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(WINDOW - 1);
    localparam logic [CLICK_W-1:0] CLICK_MAX  = CLICK_W'(MAX_CLICKS);
    localparam logic [CLICK_W-1:0] CLICK_ONE  = CLICK_W'(1);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [CLICK_W-1:0] clicks_q, clicks_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               ev_valid_q, ev_valid_d;
    logic [CLICK_W-1:0] ev_count_q, ev_count_d;
    logic               busy_q, busy_d;
    logic               overflow_q, overflow_d;

    logic               emit;
    logic [CLICK_W-1:0] emit_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            clicks_q   <= '0;
            timer_q    <= '0;
            ev_valid_q <= 1'b0;
            ev_count_q <= '0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clicks_q   <= clicks_d;
            timer_q    <= timer_d;
            ev_valid_q <= ev_valid_d;
            ev_count_q <= ev_count_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clicks_d   = clicks_q;
        timer_d    = timer_q;
        ev_valid_d = ev_valid_q;
        ev_count_d = ev_count_q;
        overflow_d = overflow_q;
        emit       = 1'b0;
        emit_count = '0;

        case (state_q)
            IDLE: begin
                if (press) begin
                    if (MAX_CLICKS == 1) begin
                        emit       = 1'b1;
                        emit_count = CLICK_ONE;
                    end else begin
                        clicks_d = CLICK_ONE;
                        timer_d  = '0;
                        state_d  = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (press && (clicks_q + CLICK_ONE == CLICK_MAX)) begin
                    emit       = 1'b1;
                    emit_count = CLICK_MAX;
                    clicks_d   = '0;
                    timer_d    = '0;
                    state_d    = IDLE;
                end else if (press) begin
                    clicks_d = clicks_q + CLICK_ONE;
                    timer_d  = '0;
                end else if (timer_q == TIMER_LAST) begin
                    emit       = 1'b1;
                    emit_count = clicks_q;
                    clicks_d   = '0;
                    timer_d    = '0;
                    state_d    = IDLE;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // An event is only replaced once the consumer has taken the old one.
        if (emit) begin
            if (!ev_valid_q || ev_ready) begin
                ev_valid_d = 1'b1;
                ev_count_d = emit_count;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (ev_valid_q && ev_ready) begin
            ev_valid_d = 1'b0;
        end

        busy_d = (state_d == COLLECT);
    end

    assign ev_valid = ev_valid_q;
    assign ev_count = ev_count_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_click_sequence_decoder.sv
// Directed scoreboard bench: expected events queued by stimulus, checked by an
// independent monitor as each new event appears on the output.
module tb_click_sequence_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       press = 1'b0;
    logic       ev_ready = 1'b1;
    logic       ev_valid;
    logic [1:0] ev_count;
    logic       busy;
    logic       overflow;

    logic       press1 = 1'b0;
    logic       ev_valid1;
    logic [1:0] ev_count1;
    logic       busy1;
    logic       overflow1;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    bit busy1_seen = 1'b0;

    typedef struct {
        int at_cyc;
        int cnt;
    } exp_t;
    exp_t exp_q[$];

    click_sequence_decoder #(
        .WINDOW(10), .TIMER_W(4), .CLICK_W(2), .MAX_CLICKS(3)
    ) dut (
        .clk(clk), .rst(rst), .press(press), .ev_ready(ev_ready),
        .ev_valid(ev_valid), .ev_count(ev_count), .busy(busy), .overflow(overflow)
    );

    click_sequence_decoder #(
        .WINDOW(10), .TIMER_W(4), .CLICK_W(2), .MAX_CLICKS(1)
    ) dut1 (
        .clk(clk), .rst(rst), .press(press1), .ev_ready(1'b1),
        .ev_valid(ev_valid1), .ev_count(ev_count1), .busy(busy1), .overflow(overflow1)
    );

    always #100 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    task automatic at(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sample_at(input int c);
        at(c);
        @(negedge clk);
    endtask

    task automatic pulse(input int c);
        at(c);
        press = 1'b1;
        at(c + 1);
        press = 1'b0;
    endtask

    task automatic expect_ev(input int c, input int n);
        exp_t e;
        e.at_cyc = c;
        e.cnt    = n;
        exp_q.push_back(e);
    endtask

    // Monitor: a new event is one that was not present, or replaced an accepted one.
    bit prev_valid = 1'b0;
    bit prev_acc   = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            prev_acc   = 1'b0;
        end else begin
            if (busy1) busy1_seen = 1'b1;
            if (ev_valid && (!prev_valid || prev_acc)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event", int'(ev_count), 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("event_cycle", cyc, e.at_cyc);
                    check("event_count", int'(ev_count), e.cnt);
                end
            end
            prev_valid = ev_valid;
            prev_acc   = ev_valid && ev_ready;
        end
    end

    initial begin
        // Reset state
        sample_at(1);
        check("rst_ev_valid", int'(ev_valid), 0);
        check("rst_ev_count", int'(ev_count), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_overflow", int'(overflow), 0);
        at(2);
        rst = 1'b0;

        // Single press
        expect_ev(16, 1);
        pulse(5);
        @(negedge clk);
        check("single_busy_start", int'(busy), 1);
        sample_at(15);
        check("single_busy_end", int'(busy), 1);
        sample_at(16);
        check("single_busy_off", int'(busy), 0);
        check("single_valid", int'(ev_valid), 1);
        check("single_count", int'(ev_count), 1);
        sample_at(17);
        check("single_valid_drop", int'(ev_valid), 0);

        // Press on the last cycle of the window merges
        expect_ev(51, 2);
        pulse(30);
        pulse(40);
        sample_at(50);
        check("merge_busy", int'(busy), 1);

        // Press one cycle too late starts a new sequence
        expect_ev(71, 1);
        expect_ev(82, 1);
        pulse(60);
        pulse(71);

        // Triple click closes immediately
        expect_ev(97, 3);
        pulse(90);
        pulse(93);
        pulse(96);
        sample_at(97);
        check("triple_busy_off", int'(busy), 0);
        check("triple_count", int'(ev_count), 3);

        // Backpressure: second event dropped
        at(115);
        ev_ready = 1'b0;
        expect_ev(131, 1);
        pulse(120);
        pulse(131);
        sample_at(140);
        check("bp_valid_held", int'(ev_valid), 1);
        check("bp_count_held", int'(ev_count), 1);
        sample_at(141);
        check("bp_overflow_pre", int'(overflow), 0);
        sample_at(142);
        check("bp_overflow_set", int'(overflow), 1);
        check("bp_count_kept", int'(ev_count), 1);
        at(150);
        ev_ready = 1'b1;
        sample_at(151);
        check("bp_valid_drained", int'(ev_valid), 0);
        check("bp_overflow_sticky", int'(overflow), 1);

        at(160);
        rst = 1'b1;
        at(161);
        rst = 1'b0;
        @(negedge clk);
        check("rst_clears_overflow", int'(overflow), 0);

        // Ready arrives exactly in the emit cycle: replace, no overflow
        at(165);
        ev_ready = 1'b0;
        expect_ev(181, 1);
        expect_ev(192, 1);
        pulse(170);
        pulse(181);
        at(191);
        ev_ready = 1'b1;
        at(192);
        ev_ready = 1'b0;
        @(negedge clk);
        check("swap_valid", int'(ev_valid), 1);
        sample_at(193);
        check("swap_no_overflow", int'(overflow), 0);
        at(200);
        ev_ready = 1'b1;

        // Reset mid-sequence discards it; press during rst ignored
        pulse(210);
        at(215);
        rst = 1'b1;
        press = 1'b1;
        at(216);
        rst = 1'b0;
        press = 1'b0;
        @(negedge clk);
        check("midrst_valid", int'(ev_valid), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_overflow", int'(overflow), 0);
        sample_at(230);
        check("midrst_busy_later", int'(busy), 0);
        check("midrst_valid_later", int'(ev_valid), 0);

        // MAX_CLICKS=1 build
        at(240);
        press1 = 1'b1;
        at(241);
        press1 = 1'b0;
        @(negedge clk);
        check("max1_valid", int'(ev_valid1), 1);
        check("max1_count", int'(ev_count1), 1);
        sample_at(242);
        check("max1_valid_drop", int'(ev_valid1), 0);

        sample_at(260);
        check("events_outstanding", exp_q.size(), 0);
        check("max1_busy_seen", int'(busy1_seen), 0);
        check("max1_overflow", int'(overflow1), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
